// File: rtl/id_stage_hs.sv
// MIPS instruction-decode stage: register file, decode, valid/ready handshake,
// load-use stall and branch/jump targets. Define ID_BYPASS_EN for write-back forwarding.
module id_stage_hs #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] pc,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] st_data,
  output logic [4:0]        rd,
  output logic [2:0]        aluctr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              reg_wr,
  output logic              branch,
  output logic              jump,
  output logic              illegal,
  output logic [DATA_W-1:0] br_target,
  output logic [DATA_W-1:0] j_target
);

  localparam int          IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int unsigned REG_NUM_U = REG_NUM;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  logic [DATA_W-1:0] r_regs [REG_NUM];

  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_st;
  logic [4:0]        r_rd;
  logic [2:0]        r_aluctr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_reg_wr;
  logic              r_branch;
  logic              r_jump;
  logic              r_illegal;
  logic [DATA_W-1:0] r_br_target;
  logic [DATA_W-1:0] r_j_target;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_pc4;
  logic [DATA_W-1:0] w_rs_raw;
  logic [DATA_W-1:0] w_rt_raw;
  logic              w_fwd_rs;
  logic              w_fwd_rt;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_use_imm;
  logic              w_uses_rt;
  logic [4:0]        w_rd;
  logic [2:0]        w_aluctr;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic              w_reg_wr;
  logic              w_branch;
  logic              w_jump;
  logic              w_illegal;
  logic              w_stall;
  logic              w_accept;
  logic              w_unused;

  assign w_op     = ir[31:26];
  assign w_funct  = ir[5:0];
  assign w_rs     = ir[25:21];
  assign w_rt     = ir[20:16];
  assign w_sext   = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign w_pc4    = pc + DATA_W'(4);
  assign w_unused = &{1'b0, ir[10:6]};

  // Register 0 and indices beyond the implemented file always read as zero.
  always_comb begin
    w_rs_raw = '0;
    w_rt_raw = '0;
    if (w_rs != 5'd0 && 32'(w_rs) < REG_NUM_U) w_rs_raw = r_regs[w_rs[IDX_W-1:0]];
    if (w_rt != 5'd0 && 32'(w_rt) < REG_NUM_U) w_rt_raw = r_regs[w_rt[IDX_W-1:0]];
  end

`ifdef ID_BYPASS_EN
  assign w_fwd_rs = wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs);
  assign w_fwd_rt = wb_we && (wb_rd != 5'd0) && (wb_rd == w_rt);
`else
  assign w_fwd_rs = 1'b0;
  assign w_fwd_rt = 1'b0;
`endif

  assign w_rs_val = w_fwd_rs ? wb_data : w_rs_raw;
  assign w_rt_val = w_fwd_rt ? wb_data : w_rt_raw;

  always_comb begin
    w_use_imm = 1'b0;
    w_uses_rt = 1'b0;
    w_rd      = 5'd0;
    w_aluctr  = 3'd0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_reg_wr  = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_uses_rt = 1'b1;
        case (w_funct)
          FN_ADD:  w_aluctr = 3'd0;
          FN_SUB:  w_aluctr = 3'd1;
          FN_SLT:  w_aluctr = 3'd2;
          FN_AND:  w_aluctr = 3'd3;
          FN_OR:   w_aluctr = 3'd4;
          default: w_illegal = 1'b1;
        endcase
        if (!w_illegal) begin
          w_rd     = ir[15:11];
          w_reg_wr = (ir[15:11] != 5'd0);
        end
      end
      OP_ADDI: begin
        w_use_imm = 1'b1;
        w_rd      = w_rt;
        w_reg_wr  = 1'b1;
      end
      OP_LW: begin
        w_use_imm = 1'b1;
        w_rd      = w_rt;
        w_mem_rd  = 1'b1;
        w_reg_wr  = 1'b1;
      end
      OP_SW: begin
        w_use_imm = 1'b1;
        w_uses_rt = 1'b1;
        w_mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        w_uses_rt = 1'b1;
        w_aluctr  = 3'd1;
        w_branch  = 1'b1;
      end
      OP_J:    w_jump = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  // A load in the output register blocks any instruction that reads its destination.
  assign w_stall  = r_valid && r_mem_rd && (r_rd != 5'd0) &&
                    ((w_rs == r_rd) || (w_uses_rt && (w_rt == r_rd)));
  assign if_ready = !w_stall && (!r_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0) && (32'(wb_rd) < REG_NUM_U)) begin
      r_regs[wb_rd[IDX_W-1:0]] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_st        <= '0;
      r_rd        <= 5'd0;
      r_aluctr    <= 3'd0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_br_target <= '0;
      r_j_target  <= '0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_a         <= w_rs_val;
      r_b         <= w_use_imm ? w_sext : w_rt_val;
      r_st        <= w_rt_val;
      r_rd        <= w_rd;
      r_aluctr    <= w_aluctr;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_reg_wr    <= w_reg_wr;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_illegal   <= w_illegal;
      r_br_target <= w_pc4 + (w_sext << 2);
      r_j_target  <= {w_pc4[DATA_W-1:28], ir[25:0], 2'b00};
    end else if (r_valid && ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign id_valid  = r_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign st_data   = r_st;
  assign rd        = r_rd;
  assign aluctr    = r_aluctr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign reg_wr    = r_reg_wr;
  assign branch    = r_branch;
  assign jump      = r_jump;
  assign illegal   = r_illegal;
  assign br_target = r_br_target;
  assign j_target  = r_j_target;

endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios plus random traffic checked against
// an instruction-level reference model of decode, register file and handshake.
module tb_id_stage_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] a, b, st_data, br_target, j_target;
  logic [4:0]  rd;
  logic [2:0]  aluctr;
  logic        mem_rd, mem_wr, reg_wr, branch, jump, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_hs dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .ir(ir), .pc(pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .id_valid(id_valid), .a(a), .b(b), .st_data(st_data),
    .rd(rd), .aluctr(aluctr), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
    .branch(branch), .jump(jump), .illegal(illegal),
    .br_target(br_target), .j_target(j_target)
  );

  typedef struct {
    logic [31:0] a, b, st, bt, jt;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic        mr, mw, rw, br, jp, il;
  } bundle_t;

  logic [31:0] mRegs [32];
  logic        mValid;
  bundle_t     mB;
  logic        expReady;
  logic        lastReady;
  bit          bypassOn;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void resetModel();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mValid = 1'b0;
    mB = '{default: '0};
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (bypassOn && we && wrd == idx) return wd;
    return mRegs[idx];
  endfunction

  function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pcv,
                                     input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    bundle_t     r;
    int          op, fn;
    logic [31:0] imm, rsv, rtv;
    r   = '{default: '0};
    op  = int'(instr[31:26]);
    fn  = int'(instr[5:0]);
    imm = 32'($signed(instr[15:0]));
    rsv = readReg(instr[25:21], we, wrd, wd);
    rtv = readReg(instr[20:16], we, wrd, wd);
    r.a  = rsv;
    r.b  = rtv;
    r.st = rtv;
    r.bt = pcv + 32'd4 + imm * 32'd4;
    r.jt = ((pcv + 32'd4) & 32'hF000_0000) + 32'(instr[25:0]) * 32'd4;
    case (op)
      0: begin
        if (fn == 32) r.alu = 0;
        else if (fn == 34) r.alu = 1;
        else if (fn == 42) r.alu = 2;
        else if (fn == 36) r.alu = 3;
        else if (fn == 37) r.alu = 4;
        else r.il = 1;
        if (!r.il) begin r.rd = instr[15:11]; r.rw = (r.rd != 0); end
      end
      8:  begin r.b = imm; r.rd = instr[20:16]; r.rw = 1; end
      35: begin r.b = imm; r.rd = instr[20:16]; r.rw = 1; r.mr = 1; end
      43: begin r.b = imm; r.mw = 1; end
      4:  begin r.alu = 1; r.br = 1; end
      2:  r.jp = 1;
      default: r.il = 1;
    endcase
    return r;
  endfunction

  function automatic logic modelReady(input logic [31:0] instr, input logic er);
    logic readsRt, hazard;
    readsRt = (instr[31:26] == 6'd0) || (instr[31:26] == 6'd43) || (instr[31:26] == 6'd4);
    hazard  = mValid && mB.mr && mB.rd != 0 &&
              (instr[25:21] == mB.rd || (readsRt && instr[20:16] == mB.rd));
    return !hazard && (!mValid || er);
  endfunction

  // One clock of traffic: drive, compare against the model mid-cycle, advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pcv,
                               input logic er, input logic we, input logic [4:0] wrd,
                               input logic [31:0] wd);
    if_valid = v; ir = instr; pc = pcv; ex_ready = er;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    #3;
    expReady  = modelReady(instr, er);
    lastReady = if_ready;
    checkOutput("if_ready", if_ready, expReady);
    checkOutput("id_valid", id_valid, mValid);
    if (mValid) begin
      checkOutput("a", a, mB.a);
      checkOutput("b", b, mB.b);
      checkOutput("st_data", st_data, mB.st);
      checkOutput("rd", rd, mB.rd);
      checkOutput("aluctr", aluctr, mB.alu);
      checkOutput("flags", {mem_rd, mem_wr, reg_wr, branch, jump, illegal},
                  {mB.mr, mB.mw, mB.rw, mB.br, mB.jp, mB.il});
      checkOutput("br_target", br_target, mB.bt);
      checkOutput("j_target", j_target, mB.jt);
    end
    if (v && expReady) begin
      mB = decode(instr, pcv, we, wrd, wd);
      mValid = 1'b1;
    end else if (mValid && er) begin
      mValid = 1'b0;
    end
    if (we && wrd != 0) mRegs[wrd] = wd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] rs, rt, rdd;
    logic [5:0] fns [6] = '{6'd32, 6'd34, 6'd42, 6'd36, 6'd37, 6'd13};
    logic [5:0] ops [4] = '{6'd8, 6'd35, 6'd43, 6'd4};
    logic [5:0] bad [4] = '{6'd1, 6'd3, 6'd17, 6'd63};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rdd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'd0, rs, rt, rdd, 5'd0, fns[$urandom_range(0, 5)]};
      3, 4, 5, 6: return {ops[$urandom_range(0, 3)], rs, rt, 16'($urandom)};
      7: return {6'd35, rs, rt, 16'($urandom)};
      8: return {6'd2, 26'($urandom)};
      default: return {bad[$urandom_range(0, 3)], 26'($urandom)};
    endcase
  endfunction

  initial begin
`ifdef ID_BYPASS_EN
    bypassOn = 1'b1;
`else
    bypassOn = 1'b0;
`endif
    resetModel();
    rst_n = 1'b0; if_valid = 0; ir = 0; pc = 0; ex_ready = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_id_valid", id_valid, 0);
    checkOutput("reset_a", a, 0);
    checkOutput("reset_if_ready", if_ready, 1);

    // Write-back then add $3,$1,$2
    applyStimulus(0, 32'h0, 32'h0, 1, 1, 5'd1, 32'd5);
    applyStimulus(0, 32'h0, 32'h0, 1, 1, 5'd2, 32'd7);
    applyStimulus(1, 32'h0022_1820, 32'h40, 1, 0, 0, 0);
    checkOutput("add_valid", id_valid, 1);
    checkOutput("add_a", a, 5);
    checkOutput("add_b", b, 7);
    checkOutput("add_rd", rd, 3);
    checkOutput("add_reg_wr", reg_wr, 1);

    // Load-use: lw $4,8($1) then add $5,$4,$2
    applyStimulus(1, 32'h8C24_0008, 32'h44, 1, 0, 0, 0);
    checkOutput("lw_mem_rd", mem_rd, 1);
    checkOutput("lw_b", b, 8);
    applyStimulus(1, 32'h0082_2820, 32'h48, 1, 0, 0, 0);
    checkOutput("lu_stall", lastReady, 0);
    checkOutput("lu_bubble", id_valid, 0);
    applyStimulus(1, 32'h0082_2820, 32'h48, 1, 0, 0, 0);
    checkOutput("lu_accept", lastReady, 1);
    checkOutput("lu_add_rd", rd, 5);

    // Backpressure: sub $6,$1,$2 waits behind the held add
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h0022_3022, 32'h4C, 0, 0, 0, 0);
      checkOutput("bp_ready", lastReady, 0);
      checkOutput("bp_hold_rd", rd, 5);
    end
    applyStimulus(1, 32'h0022_3022, 32'h4C, 1, 0, 0, 0);
    checkOutput("bp_release", lastReady, 1);
    checkOutput("bp_sub_alu", aluctr, 1);

    // Targets and store
    applyStimulus(1, 32'h1022_FFFF, 32'h100, 1, 0, 0, 0);
    checkOutput("beq_target", br_target, 32'h100);
    checkOutput("beq_branch", branch, 1);
    applyStimulus(1, 32'h0800_0040, 32'h1000_0000, 1, 0, 0, 0);
    checkOutput("j_target", j_target, 32'h1000_0100);
    checkOutput("j_jump", jump, 1);
    applyStimulus(1, 32'hAC22_FFFC, 32'h200, 1, 0, 0, 0);
    checkOutput("sw_b", b, 32'hFFFF_FFFC);
    checkOutput("sw_mem_wr", mem_wr, 1);
    checkOutput("sw_st_data", st_data, 7);

    // Boundaries: write to $0, illegal opcode, same-cycle write/read of $6
    applyStimulus(0, 32'h0, 32'h0, 1, 1, 5'd0, 32'h55);
    applyStimulus(1, 32'h0001_4020, 32'h204, 1, 0, 0, 0);
    checkOutput("r0_reads_zero", a, 0);
    applyStimulus(1, 32'hFC00_0000, 32'h208, 1, 0, 0, 0);
    checkOutput("ill_flag", illegal, 1);
    checkOutput("ill_ctrl", {mem_rd, mem_wr, reg_wr, branch, jump, rd}, 0);
    checkOutput("ill_valid", id_valid, 1);
    applyStimulus(1, 32'h00C0_3820, 32'h20C, 1, 1, 5'd6, 32'd9);
    checkOutput("same_cycle_a", a, bypassOn ? 32'd9 : 32'd0);
    applyStimulus(1, 32'h00C0_3820, 32'h210, 1, 0, 0, 0);
    checkOutput("after_write_a", a, 9);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), {$urandom} & 32'hFFFF_FFFC,
                    $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset while an instruction is held
    applyStimulus(1, 32'h0022_1820, 32'h300, 0, 1, 5'd1, 32'd11);
    applyStimulus(1, 32'h0022_1820, 32'h304, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_id_valid", id_valid, 0);
    checkOutput("arst_a", a, 0);
    checkOutput("arst_rd", rd, 0);
    checkOutput("arst_br_target", br_target, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    resetModel();
    applyStimulus(1, 32'h0022_1820, 32'h308, 1, 0, 0, 0);
    checkOutput("arst_regs_a", a, 0);
    checkOutput("arst_regs_b", b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
